// File: rtl/regfile_sb_pkg.sv
// Shared CPU register-bank package: default geometry and register data/address types.
package regfile_sb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef logic [DATA_W_DEF-1:0] reg_data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage : regfile_sb_pkg

// File: rtl/regfile_busy.sv
// Write-pending scoreboard: one busy bit per register, set by accepted issue,
// cleared by writeback, plus a sticky flag for writebacks nobody was waiting on.
module regfile_busy
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    localparam int NREG    = 2**ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              iss_ready,
    output logic [NREG-1:0]   busy_vec,
    output logic              wb_err
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic            wb_err_r;
    logic            iss_zero_s;
    logic            wb_zero_s;
    logic            iss_ready_s;
    logic            wb_act_s;
    logic            iss_act_s;

    // Issue acceptance and next busy vector; issue applied after clear so a new producer wins
    always_comb begin
        iss_zero_s  = (ZERO_REG != 0) && (iss_rd == {ADDR_W{1'b0}});
        wb_zero_s   = (ZERO_REG != 0) && (wb_addr == {ADDR_W{1'b0}});
        iss_ready_s = iss_zero_s || !busy_r[iss_rd] || (wb_en && (wb_addr == iss_rd));
        wb_act_s    = wb_en && !wb_zero_s;
        iss_act_s   = iss_valid && iss_ready_s && !iss_zero_s;
        busy_nxt_s  = busy_r;
        if (wb_act_s) begin
            busy_nxt_s[wb_addr] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (iss_act_s) begin
            busy_nxt_s[iss_rd] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // Busy state and sticky error register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy_r   <= {NREG{1'b0}};
            wb_err_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            if (wb_act_s && !busy_r[wb_addr]) begin
                wb_err_r <= 1'b1;
            end
        end
    end

    assign iss_ready = iss_ready_s;
    assign busy_vec  = busy_r;
    assign wb_err    = wb_err_r;

endmodule : regfile_busy

// File: rtl/regfile_sb.sv
// Register file with two bypassed combinational read ports, one clocked write
// port and an integrated write-pending scoreboard for RAW/WAW stalls.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    localparam int NREG    = 2**ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_rdy_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_rdy_b,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ready,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [NREG-1:0]   busy_vec,
    output logic              wb_err
);

    logic [DATA_W-1:0] mem_r [NREG];
    logic [NREG-1:0]   busy_s;
    logic              wb_zero_s;
    logic [ADDR_W-1:0] rd_addr_s [2];
    logic [DATA_W-1:0] rd_data_s [2];
    logic              rd_rdy_s  [2];

    assign wb_zero_s    = (ZERO_REG != 0) && (wb_addr == {ADDR_W{1'b0}});
    assign rd_addr_s[0] = rd_addr_a;
    assign rd_addr_s[1] = rd_addr_b;

    regfile_busy #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .CLK       (CLK),
        .RESET     (RESET),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .iss_ready (iss_ready),
        .busy_vec  (busy_s),
        .wb_err    (wb_err)
    );

    // Register array; reset clears every entry asynchronously
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_en && !wb_zero_s) begin
            mem_r[wb_addr] <= wb_data;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        // Read mux: hardwired zero, then same-cycle writeback bypass, then array
        always_comb begin
            if ((ZERO_REG != 0) && (rd_addr_s[p] == {ADDR_W{1'b0}})) begin
                rd_data_s[p] = {DATA_W{1'b0}};
                rd_rdy_s[p]  = 1'b1;
            end else if (wb_en && (wb_addr == rd_addr_s[p])) begin
                rd_data_s[p] = wb_data;
                rd_rdy_s[p]  = 1'b1;
            end else begin
                rd_data_s[p] = mem_r[rd_addr_s[p]];
                rd_rdy_s[p]  = !busy_s[rd_addr_s[p]];
            end
        end
    end

    assign rd_data_a = rd_data_s[0];
    assign rd_rdy_a  = rd_rdy_s[0];
    assign rd_data_b = rd_data_s[1];
    assign rd_rdy_b  = rd_rdy_s[1];
    assign busy_vec  = busy_s;

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 16x16 instance and a 32x32 zero-register instance,
// checked each cycle against an array-based model plus directed literal checks.
module tb_regfile_sb;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        chk_on = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic [4:0]  ra [2];
    logic [4:0]  rb [2];
    logic [4:0]  ird [2];
    logic [4:0]  wa [2];
    logic        iv [2];
    logic        we [2];
    logic [31:0] wd [2];

    logic [15:0] d0a, d0b, bv0;
    logic        r0a, r0b, ir0, e0;
    logic [31:0] d1a, d1b, bv1;
    logic        r1a, r1b, ir1, e1;

    logic [31:0] m_reg  [2][32];
    logic        m_busy [2][32];
    logic        m_err  [2];

    always #5 CLK = ~CLK;

    regfile_sb u0 (
        .CLK(CLK), .RESET(RESET),
        .rd_addr_a(ra[0][3:0]), .rd_data_a(d0a), .rd_rdy_a(r0a),
        .rd_addr_b(rb[0][3:0]), .rd_data_b(d0b), .rd_rdy_b(r0b),
        .iss_valid(iv[0]), .iss_rd(ird[0][3:0]), .iss_ready(ir0),
        .wb_en(we[0]), .wb_addr(wa[0][3:0]), .wb_data(wd[0][15:0]),
        .busy_vec(bv0), .wb_err(e0)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u1 (
        .CLK(CLK), .RESET(RESET),
        .rd_addr_a(ra[1]), .rd_data_a(d1a), .rd_rdy_a(r1a),
        .rd_addr_b(rb[1]), .rd_data_b(d1b), .rd_rdy_b(r1b),
        .iss_valid(iv[1]), .iss_rd(ird[1]), .iss_ready(ir1),
        .wb_en(we[1]), .wb_addr(wa[1]), .wb_data(wd[1]),
        .busy_vec(bv1), .wb_err(e1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] dmask(input int k);
        return (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic int nreg(input int k);
        return (k == 0) ? 16 : 32;
    endfunction

    function automatic logic is_r0(input int k, input logic [4:0] a);
        return (k == 1) && (a == 5'd0);
    endfunction

    function automatic logic [31:0] exp_data(input int k, input logic [4:0] a);
        if (is_r0(k, a)) return 32'h0;
        if (we[k] && wa[k] == a) return wd[k] & dmask(k);
        return m_reg[k][a];
    endfunction

    function automatic logic exp_rdy(input int k, input logic [4:0] a);
        if (is_r0(k, a)) return 1'b1;
        if (we[k] && wa[k] == a) return 1'b1;
        return !m_busy[k][a];
    endfunction

    function automatic logic exp_iss(input int k);
        return is_r0(k, ird[k]) || !m_busy[k][ird[k]] || (we[k] && wa[k] == ird[k]);
    endfunction

    function automatic logic [31:0] exp_bv(input int k);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nreg(k); i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    always @(posedge CLK or negedge RESET) begin
        for (int k = 0; k < 2; k++) begin
            if (!RESET) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[k][i]  <= 32'h0;
                    m_busy[k][i] <= 1'b0;
                end
                m_err[k] <= 1'b0;
            end else begin
                if (we[k] && !is_r0(k, wa[k])) begin
                    if (!m_busy[k][wa[k]]) m_err[k] <= 1'b1;
                    m_reg[k][wa[k]]  <= wd[k] & dmask(k);
                    m_busy[k][wa[k]] <= 1'b0;
                end
                if (iv[k] && exp_iss(k) && !is_r0(k, ird[k]))
                    m_busy[k][ird[k]] <= 1'b1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge CLK) begin
        if (chk_on) begin
            check("u0 rd_data_a", {16'h0, d0a}, exp_data(0, ra[0]));
            check("u0 rd_rdy_a",  {31'h0, r0a}, {31'h0, exp_rdy(0, ra[0])});
            check("u0 rd_data_b", {16'h0, d0b}, exp_data(0, rb[0]));
            check("u0 rd_rdy_b",  {31'h0, r0b}, {31'h0, exp_rdy(0, rb[0])});
            check("u0 iss_ready", {31'h0, ir0}, {31'h0, exp_iss(0)});
            check("u0 busy_vec",  {16'h0, bv0}, exp_bv(0));
            check("u0 wb_err",    {31'h0, e0},  {31'h0, m_err[0]});
            check("u1 rd_data_a", d1a, exp_data(1, ra[1]));
            check("u1 rd_rdy_a",  {31'h0, r1a}, {31'h0, exp_rdy(1, ra[1])});
            check("u1 rd_data_b", d1b, exp_data(1, rb[1]));
            check("u1 rd_rdy_b",  {31'h0, r1b}, {31'h0, exp_rdy(1, rb[1])});
            check("u1 iss_ready", {31'h0, ir1}, {31'h0, exp_iss(1)});
            check("u1 busy_vec",  bv1, exp_bv(1));
            check("u1 wb_err",    {31'h0, e1},  {31'h0, m_err[1]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h0100_0193) ^ 32'h5A5A_5A5A;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            ra[k] = 5'd0; rb[k] = 5'd0; ird[k] = 5'd0; wa[k] = 5'd0;
            iv[k] = 1'b0; we[k] = 1'b0; wd[k] = 32'h0;
        end
        RESET = 1'b1;
        #1 RESET = 1'b0;
        #20 RESET = 1'b1;
        step();
        chk_on = 1'b1;

        // reset state
        @(negedge CLK);
        check("rst busy_vec", {16'h0, bv0}, 32'h0);
        check("rst wb_err", {31'h0, e0}, 32'h0);
        check("rst iss_ready", {31'h0, ir0}, 32'h1);
        check("rst rd_rdy_a", {31'h0, r0a}, 32'h1);
        check("rst rd_data_a", {16'h0, d0a}, 32'h0);

        // first write with bypass, then array read and wb_err
        step();
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h1234; ra[0] = 5'd3;
        @(negedge CLK);
        check("bypass r3 data", {16'h0, d0a}, 32'h1234);
        check("bypass r3 rdy", {31'h0, r0a}, 32'h1);
        step();
        we[0] = 1'b0;
        @(negedge CLK);
        check("array r3 data", {16'h0, d0a}, 32'h1234);
        check("wb_err set", {31'h0, e0}, 32'h1);

        // RAW stall on r5
        step();
        iv[0] = 1'b1; ird[0] = 5'd5; rb[0] = 5'd5;
        step();
        iv[0] = 1'b0;
        @(negedge CLK);
        check("raw busy5", {31'h0, bv0[5]}, 32'h1);
        check("raw rdy_b stall", {31'h0, r0b}, 32'h0);
        step();
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hBEEF;
        @(negedge CLK);
        check("raw rdy_b bypass", {31'h0, r0b}, 32'h1);
        check("raw data_b bypass", {16'h0, d0b}, 32'hBEEF);
        step();
        we[0] = 1'b0;
        @(negedge CLK);
        check("raw busy5 clear", {31'h0, bv0[5]}, 32'h0);

        // WAW stall on r7
        step();
        iv[0] = 1'b1; ird[0] = 5'd7;
        step();
        @(negedge CLK);
        check("waw iss_ready stall", {31'h0, ir0}, 32'h0);
        step();
        @(negedge CLK);
        check("waw busy unchanged", {16'h0, bv0}, 32'h0080);
        we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h7777;
        #1;
        check("waw iss_ready wb", {31'h0, ir0}, 32'h1);
        step();
        we[0] = 1'b0; iv[0] = 1'b0; ra[0] = 5'd7;
        @(negedge CLK);
        check("waw busy7 kept", {16'h0, bv0}, 32'h0080);
        check("waw r7 data", {16'h0, d0a}, 32'h7777);
        check("waw r7 not rdy", {31'h0, r0a}, 32'h0);

        // reset pulse between edges
        step();
        we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 32'hAAAA; iv[0] = 1'b1; ird[0] = 5'd2;
        step();
        we[0] = 1'b0; ird[0] = 5'd9;
        step();
        iv[0] = 1'b0; ra[0] = 5'd4; rb[0] = 5'd2;
        @(negedge CLK);
        check("pre-rst busy", {16'h0, bv0}, 32'h0284);
        check("pre-rst r4", {16'h0, d0a}, 32'hAAAA);
        #2 RESET = 1'b0;
        #1;
        check("mid-rst busy", {16'h0, bv0}, 32'h0);
        check("mid-rst r4", {16'h0, d0a}, 32'h0);
        check("mid-rst r2", {16'h0, d0b}, 32'h0);
        check("mid-rst wb_err", {31'h0, e0}, 32'h0);
        #1 RESET = 1'b1;

        // ZERO_REG instance: write and issue r0
        step();
        we[1] = 1'b1; wa[1] = 5'd0; wd[1] = 32'hFFFF_FFFF; iv[1] = 1'b1; ird[1] = 5'd0;
        ra[1] = 5'd0;
        @(negedge CLK);
        check("z iss_ready", {31'h0, ir1}, 32'h1);
        check("z r0 data", d1a, 32'h0);
        step();
        we[1] = 1'b0; iv[1] = 1'b0;
        @(negedge CLK);
        check("z busy_vec", bv1, 32'h0);
        check("z wb_err", {31'h0, e1}, 32'h0);
        check("z r0 after", d1a, 32'h0);

        // full sweep on the 32x32 instance
        for (int i = 0; i < 32; i++) begin
            step();
            we[1] = 1'b1; wa[1] = 5'(i); wd[1] = pat(i);
        end
        step();
        we[1] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra[1] = 5'(i); rb[1] = 5'(31 - i);
            @(negedge CLK);
            check("sweep a", d1a, (i == 0) ? 32'h0 : pat(i));
            check("sweep b", d1b, (i == 31) ? 32'h0 : pat(31 - i));
            step();
        end
        check("sweep wb_err", {31'h0, e1}, 32'h1);

        step();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with an integrated write-pending scoreboard, the next generation of the CPU register bank. It provides two combinational read ports with same-cycle writeback bypass, one clocked write port, and an issue-side reservation interface that tracks which registers await a result. Decode uses the per-port ready flags to stall on RAW hazards and `iss_ready` to stall on WAW hazards. Writeback clears the pending state.

## Interface
- `DATA_W`, default 16: register width in bits.
- `ADDR_W`, default 4: address width; depth is `NREG = 2**ADDR_W`.
- `ZERO_REG`, default 0: when 1, register 0 always reads 0, and writes and reservations to it are ignored.
- `CLK` input, 1 bit: clock; all state updates on the rising edge.
- `RESET` input, 1 bit: reset, asynchronous, active-low.
- `rd_addr_a` input, `ADDR_W`: read port A address.
- `rd_data_a` output, `DATA_W`: read port A data (combinational).
- `rd_rdy_a` output, 1 bit: port A data is current (no pending write, or bypassed).
- `rd_addr_b` input, `ADDR_W`: read port B address.
- `rd_data_b` output, `DATA_W`: read port B data.
- `rd_rdy_b` output, 1 bit: port B ready.
- `iss_valid` input, 1 bit: instruction issuing with destination `iss_rd`.
- `iss_rd` input, `ADDR_W`: destination register to reserve.
- `iss_ready` output, 1 bit: reservation accepted this cycle if `iss_valid`.
- `wb_en` input, 1 bit: write enable.
- `wb_addr` input, `ADDR_W`: write address.
- `wb_data` input, `DATA_W`: write data.
- `busy_vec` output, `NREG`: registered pending bit per register.
- `wb_err` output, 1 bit: sticky; set on a writeback to a non-busy register.

## Operation
**Storage and reset**
- Storage is `NREG` × `DATA_W`, plus `busy[NREG]` and `wb_err`.
- Reset clears all registers, all busy bits and `wb_err`.
- Reset outputs: `busy_vec = 0`, `wb_err = 0`, `iss_ready = 1`, `rd_rdy_* = 1`, `rd_data_* = 0` (unless bypassing).

**Reads** (per port, combinational)
- If `ZERO_REG` and addr = 0: data = 0, rdy = 1.
- Else if `wb_en` and `wb_addr` = addr: data = `wb_data`, rdy = 1 (bypass).
- Else: data = reg[addr], rdy = !busy[addr].

**Writes**
- `wb_en` writes `wb_data` to reg[`wb_addr`] and clears busy[`wb_addr`] at the edge.
- If `ZERO_REG` and `wb_addr` = 0, the write is ignored.

**Issue**
- `iss_ready` = !busy[`iss_rd`] OR (`wb_en` AND `wb_addr` = `iss_rd`).
- `iss_ready` is also 1 when `ZERO_REG` and `iss_rd` = 0.
- `iss_valid` AND `iss_ready` sets busy[`iss_rd`], except for register 0 under `ZERO_REG`.
- `iss_valid` with `iss_ready` = 0 changes no state; the caller holds the request.

**Simultaneous events, same register**
- Writeback and accepted issue in the same cycle: data is written and busy ends at 1 (the new producer wins).

**Error flag**
- `wb_en` to a register with busy = 0 still writes the data and sets `wb_err`.
- Register 0 under `ZERO_REG` is exempt.
- `wb_err` clears only on reset.

## Timing
- Read latency is 0 cycles; a write is visible through the array on the cycle after the edge and through the bypass in the same cycle.
- `busy_vec` and `wb_err` change only at edges; `iss_ready` and `rd_rdy_*` are combinational from the current state and inputs.
- Reset assertion mid-operation clears state immediately, without waiting for a clock edge.
- In the cycle of `RESET` release, a write or issue applies at the first edge that sees `RESET` = 1.

## Structure
- The shared CPU package holds `DATA_W`/`ADDR_W` defaults and the `reg_addr_t`/`reg_data_t` typedefs.
- Sub-module `regfile_busy` holds the busy vector, the issue/writeback set/clear logic and `wb_err`.
- The top level holds the array, the read muxes and the bypass.

## Test plan
- **Reset and first write:** after reset, write r3 = 0x1234 with no reservation. Same cycle: port A at r3 returns 0x1234 via bypass. Next cycle: the array read returns 0x1234 and `wb_err` = 1.
- **RAW stall:** issue r5, so `busy_vec[5]` = 1 and port B at r5 reads `rd_rdy_b` = 0. Writeback r5 = 0xBEEF: that cycle gives `rd_rdy_b` = 1 and data 0xBEEF. Next cycle: `busy_vec[5]` = 0.
- **WAW stall:** with r7 busy, `iss_valid` for r7 gives `iss_ready` = 0 and `busy_vec` is unchanged. In the cycle writeback r7 occurs, `iss_ready` = 1; after the edge, busy[7] = 1 and r7 holds the written data.
- **ZERO_REG = 1:** write r0 = 0xFFFF and issue r0. Result: `iss_ready` = 1, r0 reads 0, `busy_vec[0]` = 0, `wb_err` = 0.
- **Reset mid-operation:** with r2 and r9 busy and data loaded, pulse `RESET` low between edges. Result: `busy_vec` = 0 and all reads return 0 immediately.
- **Parameter sweep:** run `DATA_W` = 32, `ADDR_W` = 5; write then read back all 32 registers with distinct patterns.
